// File: rtl/cpu_sequencer.sv
// cpu_sequencer: three-cycle fetch/decode/execute sequencer feeding a 16x8
// register file and ALU. Holds the program counter and instruction register.
// Instructions are 16 bits: [15:12] opcode, [11:8] WA, [7:4] RA1, [3:0] RA2.
// For immediate forms, [7:0] is imm8.
//
// Ports:
//   clk, reset_n  : clock and async active-low reset
//   run           : allows leaving FETCH; when low, the sequencer stalls at
//                   the next FETCH
//   instr         : ROM data at address pc (combinational)
//   rd1_zero      : register file RD1 == 0, sampled by BEQZ in EXECUTE
//   pc            : instruction ROM address
//   RA1/RA2/WA    : register file read/write addresses taken from IR
//   alu_op        : ALU function (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 PASSB)
//   imm           : IR[7:0]
//   use_imm       : ALU B operand selects imm
//   write_enable  : register file write strobe, high in EXECUTE only
//   halted        : high while in the terminal HALT state
//
// Outputs other than pc are decoded from the registered state and IR only,
// so they carry no combinational path from any input.
module cpu_sequencer #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [15:0]         instr,
  input  logic                rd1_zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          RA1,
  output logic [3:0]          RA2,
  output logic [3:0]          WA,
  output logic [2:0]          alu_op,
  output logic [7:0]          imm,
  output logic                use_imm,
  output logic                write_enable,
  output logic                halted
);

  localparam int unsigned IR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [IR_W-1:0]     ir, ir_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] imm_pc;

  // Field extraction from the instruction register
  assign opcode = ir[15:12];
  assign WA     = ir[11:8];
  assign RA1    = ir[7:4];
  assign RA2    = ir[3:0];
  assign imm    = ir[7:0];
  // Jump target: imm8 zero-extended or truncated to the PC width
  assign imm_pc = PC_WIDTH'(ir[7:0]);

  // State, IR and PC registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      ir    <= '0;
      pc    <= PC_WIDTH'(RESET_PC);
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state, IR/PC update and output decode
  always_comb begin
    state_nxt    = state;
    ir_nxt       = ir;
    pc_nxt       = pc;
    alu_op       = ALU_ADD;
    use_imm      = 1'b0;
    write_enable = 1'b0;
    halted       = 1'b0;

    case (state)
      S_FETCH: begin
        if (run) begin
          ir_nxt    = instr;
          state_nxt = S_DECODE;
        end
      end

      // RA1/RA2 are already on the register file; give RD1/RD2 a cycle
      S_DECODE: state_nxt = S_EXECUTE;

      S_EXECUTE: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + PC_WIDTH'(1);
        case (opcode)
          OP_ADD:  begin alu_op = ALU_ADD; write_enable = 1'b1; end
          OP_SUB:  begin alu_op = ALU_SUB; write_enable = 1'b1; end
          OP_AND:  begin alu_op = ALU_AND; write_enable = 1'b1; end
          OP_OR:   begin alu_op = ALU_OR;  write_enable = 1'b1; end
          OP_XOR:  begin alu_op = ALU_XOR; write_enable = 1'b1; end
          OP_LDI: begin
            alu_op       = ALU_PASSB;
            use_imm      = 1'b1;
            write_enable = 1'b1;
          end
          OP_ADDI: begin
            alu_op       = ALU_ADD;
            use_imm      = 1'b1;
            write_enable = 1'b1;
          end
          OP_JMP:  pc_nxt = imm_pc;
          OP_BEQZ: begin
            if (rd1_zero) pc_nxt = imm_pc;
          end
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          // NOP and the unassigned opcodes A-E only advance the PC
          OP_NOP:  ;
          default: ;
        endcase
      end

      // Terminal; only reset_n leaves this state
      S_HALT: halted = 1'b1;

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. A program ROM in the bench feeds
// instr from pc. The reference model works one instruction at a time: it
// knows the PC, the instruction being run, and the expected control outputs
// for each of the three phases.
module tb_cpu_sequencer;

  localparam int unsigned PC_WIDTH = 8;
  localparam int unsigned RESET_PC = 0;

  logic                clk;
  logic                reset_n;
  logic                run;
  logic [15:0]         instr;
  logic                rd1_zero;
  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          RA1, RA2, WA;
  logic [2:0]          alu_op;
  logic [7:0]          imm;
  logic                use_imm;
  logic                write_enable;
  logic                halted;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;

  cpu_sequencer #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .instr(instr),
    .rd1_zero(rd1_zero), .pc(pc), .RA1(RA1), .RA2(RA2), .WA(WA),
    .alu_op(alu_op), .imm(imm), .use_imm(use_imm),
    .write_enable(write_enable), .halted(halted)
  );

  assign instr = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected ALU function, immediate select and write strobe for an opcode
  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    case (op)
      4'h2:    return 3'd1;
      4'h3:    return 3'd2;
      4'h4:    return 3'd3;
      4'h5:    return 3'd4;
      4'h6:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic exp_we(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

  function automatic logic exp_imm(input logic [3:0] op);
    return (op == 4'h6) || (op == 4'h7);
  endfunction

  // Checks the outputs that must be quiet outside EXECUTE
  task automatic chk_idle(input string ph);
    chk({ph, "_we"}, 32'(write_enable), 32'd0);
    chk({ph, "_alu"}, 32'(alu_op), 32'd0);
    chk({ph, "_useimm"}, 32'(use_imm), 32'd0);
    chk({ph, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Asynchronous reset: outputs clear immediately; released on a negedge
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'(RESET_PC));
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ra1", 32'(RA1), 32'd0);
    chk("rst_wa", 32'(WA), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    @(negedge clk);
    m_pc    = 8'(RESET_PC);
    m_ir    = 16'h0000;
    run     = 1'b1;
    reset_n = 1'b1;
  endtask

  // Runs one instruction. Entered and left at a negedge with the DUT in
  // FETCH. zsel: 0/1 forces rd1_zero in EXECUTE, 2 randomizes it.
  // stall_ok enables random run drops.
  task automatic do_instr(input int zsel, input bit stall_ok);
    logic [15:0] ir;
    logic [3:0]  op;
    logic        z;
    int          n;
    bit          stall;

    // FETCH, possibly stalled; IR-derived outputs hold the previous instruction
    chk("f_pc", 32'(pc), 32'(m_pc));
    chk("f_ra1", 32'(RA1), 32'(m_ir[7:4]));
    chk_idle("f");
    stall = (run == 1'b0) || (stall_ok && ($urandom_range(0, 3) == 0));
    if (stall) begin
      run = 1'b0;
      n = $urandom_range(1, 3);
      repeat (n) begin
        @(negedge clk);
        chk("stall_pc", 32'(pc), 32'(m_pc));
        chk("stall_wa", 32'(WA), 32'(m_ir[11:8]));
        chk("stall_we", 32'(write_enable), 32'd0);
      end
      run = 1'b1;
    end
    ir = rom[m_pc];
    op = ir[15:12];

    // DECODE: run dropping here must not affect this instruction
    @(negedge clk);
    if (stall_ok) run = 1'($urandom_range(0, 1));
    chk("d_pc", 32'(pc), 32'(m_pc));
    chk("d_ra1", 32'(RA1), 32'(ir[7:4]));
    chk("d_ra2", 32'(RA2), 32'(ir[3:0]));
    chk("d_wa", 32'(WA), 32'(ir[11:8]));
    chk("d_imm", 32'(imm), 32'(ir[7:0]));
    chk_idle("d");

    // EXECUTE
    @(negedge clk);
    z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
    rd1_zero = z;
    chk("x_pc", 32'(pc), 32'(m_pc));
    chk("x_we", 32'(write_enable), 32'(exp_we(op)));
    chk("x_alu", 32'(alu_op), 32'(exp_alu(op)));
    chk("x_useimm", 32'(use_imm), 32'(exp_imm(op)));
    chk("x_wa", 32'(WA), 32'(ir[11:8]));
    chk("x_halted", 32'(halted), 32'd0);

    if (op == 4'h8 || (op == 4'h9 && z))
      m_pc = ir[7:0];
    else if (op != 4'hF)
      m_pc = m_pc + 8'd1;
    m_ir = ir;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    run      = 1'b0;
    rd1_zero = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    m_pc = '0;
    m_ir = '0;
    @(negedge clk);
    do_reset();

    // LDI r1,5 then ADD r2,r1,r1
    rom[0] = 16'h6105;
    rom[1] = 16'h1211;
    do_instr(0, 1'b0);
    do_instr(0, 1'b0);
    chk("ldi_add_pc", 32'(pc), 32'd2);

    // BEQZ taken and not taken
    do_reset();
    rom[0] = 16'h9010;
    rom[16] = 16'h9020;
    do_instr(1, 1'b0);
    chk("beqz_taken", 32'(pc), 32'h10);
    do_instr(0, 1'b0);
    chk("beqz_not_taken", 32'(pc), 32'h11);

    // JMP to 0xFF, NOP wrap at 0xFF, then JMP at 0xFF to 0x00
    do_reset();
    rom[0] = 16'h80FF;
    rom[255] = 16'h0000;
    do_instr(2, 1'b0);
    chk("jmp_ff", 32'(pc), 32'hFF);
    do_instr(2, 1'b0);
    chk("nop_wrap", 32'(pc), 32'h00);
    do_instr(2, 1'b0);
    rom[255] = 16'h8000;
    do_instr(2, 1'b0);
    chk("jmp_at_ff", 32'(pc), 32'h00);

    // Reset while an ADD is in EXECUTE
    do_reset();
    rom[0] = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    chk("rx_we_before", 32'(write_enable), 32'd1);
    #2;
    do_reset();
    do_instr(2, 1'b0);
    chk("rx_restart_pc", 32'(pc), 32'd1);

    // Random program with random stalls; HALT excluded here
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:12] == 4'hF) rom[i][15:12] = 4'($urandom_range(0, 14));
    end
    for (int k = 0; k < 300; k++) do_instr(2, 1'b1);

    // HALT: frozen for 20 cycles, then cleared by reset
    rom[m_pc] = 16'hF000;
    do_instr(2, 1'b0);
    repeat (20) begin
      chk("h_halted", 32'(halted), 32'd1);
      chk("h_pc", 32'(pc), 32'(m_pc));
      chk("h_we", 32'(write_enable), 32'd0);
      @(negedge clk);
    end
    do_reset();
    chk("h_cleared", 32'(halted), 32'd0);
    rom[0] = 16'h7A33;
    do_instr(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
